// File: rtl/onewire_scratchpad.sv
// 1-Wire scratchpad: DEPTH-byte register file with masked host writes, a wrapping read pointer
// and an optional bit-serial Dallas/Maxim CRC-8 engine (enable with `define ONEWIRE_SCRATCHPAD_CRC_EN).
module onewire_scratchpad #(
    parameter int                 DEPTH   = 9,
    parameter int                 AW      = 4,
    parameter logic [DEPTH-1:0]   WMASK   = 9'h01C,
    parameter logic [DEPTH*8-1:0] RST_VAL = {8'h10, 8'h96, 8'hFF, 8'h7F, 8'h46,
                                             8'h4B, 8'h00, 8'hFF, 8'h50}
) (
    input  logic          clk_2m4,
    input  logic          owpo_rstn,
    input  logic          owsp_wr_en,
    input  logic [AW-1:0] owsp_wr_addr,
    input  logic [7:0]    owsp_wr_data,
    input  logic          owsp_rd_start,
    input  logic [AW-1:0] owsp_rd_addr,
    input  logic          owsp_rd_next,
    output logic [7:0]    owsp_rd_data,
    output logic          owsp_rd_last,
    output logic          owsp_wr_err,
    output logic          owsp_crc_busy,
    output logic [7:0]    owsp_crc
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [7:0]    rd_byte;
    logic          mask_bit;
    logic          wr_accept;
    logic          wr_err_q;
    logic          crc_done;
    logic [7:0]    crc_next;

    // Addresses at or beyond DEPTH never match, so they read as "not writable".
    always_comb begin
        mask_bit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (owsp_wr_addr == AW'(i)) mask_bit = WMASK[i];
        end
    end

`ifdef ONEWIRE_SCRATCHPAD_CRC_EN
    assign wr_accept = owsp_wr_en && mask_bit && (owsp_wr_addr != LAST);
`else
    assign wr_accept = owsp_wr_en && mask_bit;
`endif

    always_comb begin
        rd_byte = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_ptr == AW'(i)) rd_byte = mem[i];
        end
    end

    assign owsp_rd_data = rd_byte;
    assign owsp_rd_last = (rd_ptr == LAST);
    assign owsp_wr_err  = wr_err_q;

    always_ff @(posedge clk_2m4 or negedge owpo_rstn) begin
        if (!owpo_rstn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= RST_VAL[i*8 +: 8];
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_accept && (owsp_wr_addr == AW'(i))) mem[i] <= owsp_wr_data;
            end
            if (crc_done) mem[DEPTH-1] <= crc_next;
        end
    end

    // rd_start has priority over rd_next; out-of-range start addresses fall back to byte 0.
    always_ff @(posedge clk_2m4 or negedge owpo_rstn) begin
        if (!owpo_rstn) begin
            rd_ptr   <= '0;
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= owsp_wr_en && !wr_accept;
            if (owsp_rd_start) begin
                rd_ptr <= (owsp_rd_addr <= LAST) ? owsp_rd_addr : '0;
            end else if (owsp_rd_next) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
        end
    end

`ifdef ONEWIRE_SCRATCHPAD_CRC_EN
    typedef enum logic {IDLE, RUN} crc_state_t;

    localparam logic [AW-1:0] PEN = AW'(DEPTH - 2);

    crc_state_t    state_q, state_d;
    logic [AW-1:0] byte_q, byte_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    acc_q, acc_d;
    logic [7:0]    crc_q;
    logic [7:0]    cur_byte;
    logic          fb;

    // Any accepted write restarts the checksum from scratch; otherwise RUN eats one bit per cycle.
    always_comb begin
        cur_byte = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            if (byte_q == AW'(i)) cur_byte = mem[i];
        end
        fb       = acc_q[0] ^ cur_byte[bit_q];
        crc_next = {1'b0, acc_q[7:1]} ^ (fb ? 8'h8C : 8'h00);

        state_d  = state_q;
        byte_d   = byte_q;
        bit_d    = bit_q;
        acc_d    = acc_q;
        crc_done = 1'b0;

        if (wr_accept) begin
            state_d = RUN;
            byte_d  = '0;
            bit_d   = '0;
            acc_d   = 8'h00;
        end else if (state_q == RUN) begin
            acc_d = crc_next;
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
                if (byte_q == PEN) begin
                    crc_done = 1'b1;
                    state_d  = IDLE;
                end else begin
                    byte_d = byte_q + 1'b1;
                end
            end
        end
    end

    // Reset starts a fresh pass over the reset image; a reset mid-pass drops the partial result.
    always_ff @(posedge clk_2m4 or negedge owpo_rstn) begin
        if (!owpo_rstn) begin
            state_q <= RUN;
            byte_q  <= '0;
            bit_q   <= '0;
            acc_q   <= 8'h00;
            crc_q   <= RST_VAL[(DEPTH-1)*8 +: 8];
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            bit_q   <= bit_d;
            acc_q   <= acc_d;
            if (crc_done) crc_q <= crc_next;
        end
    end

    assign owsp_crc_busy = (state_q == RUN);
    assign owsp_crc      = crc_q;
`else
    assign crc_done      = 1'b0;
    assign crc_next      = 8'h00;
    assign owsp_crc_busy = 1'b0;
    assign owsp_crc      = 8'h00;
`endif

endmodule

// File: tb/tb_onewire_scratchpad.sv
// Scoreboard bench for onewire_scratchpad at default parameters; stimulus queues expected
// outputs {rd_data, rd_last, wr_err, crc_busy, crc}, a negedge monitor compares them.
module tb_onewire_scratchpad;

`ifdef ONEWIRE_SCRATCHPAD_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic       clk_2m4 = 1'b0;
    logic       owpo_rstn;
    logic       owsp_wr_en;
    logic [3:0] owsp_wr_addr;
    logic [7:0] owsp_wr_data;
    logic       owsp_rd_start;
    logic [3:0] owsp_rd_addr;
    logic       owsp_rd_next;
    logic [7:0] owsp_rd_data;
    logic       owsp_rd_last;
    logic       owsp_wr_err;
    logic       owsp_crc_busy;
    logic [7:0] owsp_crc;

    onewire_scratchpad dut (
        .clk_2m4      (clk_2m4),
        .owpo_rstn    (owpo_rstn),
        .owsp_wr_en   (owsp_wr_en),
        .owsp_wr_addr (owsp_wr_addr),
        .owsp_wr_data (owsp_wr_data),
        .owsp_rd_start(owsp_rd_start),
        .owsp_rd_addr (owsp_rd_addr),
        .owsp_rd_next (owsp_rd_next),
        .owsp_rd_data (owsp_rd_data),
        .owsp_rd_last (owsp_rd_last),
        .owsp_wr_err  (owsp_wr_err),
        .owsp_crc_busy(owsp_crc_busy),
        .owsp_crc     (owsp_crc)
    );

    always #5 clk_2m4 = ~clk_2m4;

    typedef struct {
        int          cyc;
        string       name;
        logic [18:0] exp;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    bit         drain_timeout = 1'b0;

    logic [7:0] exp_mem [9];
    int         exp_ptr;
    logic       exp_busy;
    logic [7:0] exp_crc;

    always @(posedge clk_2m4) cyc <= cyc + 1;

    // Monitor: compares every expectation stamped for the current cycle.
    always @(negedge clk_2m4) begin
        exp_t        e;
        logic [18:0] act;
        act = {owsp_rd_data, owsp_rd_last, owsp_wr_err, owsp_crc_busy, owsp_crc};
        while (sb.size() > 0 && (sb[0].cyc <= cyc || drain_timeout)) begin
            e = sb.pop_front();
            n_checks++;
            if (drain_timeout) begin
                n_fail++;
                $display("[TB] FAIL %s: never sampled, expected %h", e.name, e.exp);
            end else if (act !== e.exp) begin
                n_fail++;
                $display("[TB] FAIL %s: got data=%h last=%b err=%b busy=%b crc=%h, expected data=%h last=%b err=%b busy=%b crc=%h",
                         e.name, act[18:11], act[10], act[9], act[8], act[7:0],
                         e.exp[18:11], e.exp[10], e.exp[9], e.exp[8], e.exp[7:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk_2m4);
        #1;
    endtask

    task automatic push(input string name, input logic err);
        exp_t e;
        e.cyc  = cyc;
        e.name = name;
        e.exp  = {exp_mem[exp_ptr], (exp_ptr == 8), err, exp_busy, exp_crc};
        sb.push_back(e);
    endtask

    task automatic load_reset_image();
        exp_mem = '{8'h50, 8'hFF, 8'h00, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h96, 8'h10};
        exp_ptr  = 0;
        exp_busy = CRC_ON;
        exp_crc  = CRC_ON ? 8'h10 : 8'h00;
    endtask

    // Reference Dallas/Maxim CRC-8 over bytes 0..7, LSB first.
    function automatic logic [7:0] model_crc();
        logic [7:0] c;
        logic       f;
        c = 8'h00;
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 8; k++) begin
                f = c[0] ^ exp_mem[b][k];
                c = (c >> 1) ^ (f ? 8'h8C : 8'h00);
            end
        end
        return c;
    endfunction

    task automatic wait_crc();
        if (CRC_ON) begin
            repeat (63) tick();
            push("crc_running", 1'b0);
            tick();
            exp_crc    = model_crc();
            exp_mem[8] = exp_crc;
            exp_busy   = 1'b0;
            push("crc_done", 1'b0);
        end else begin
            tick();
            push("no_crc_idle", 1'b0);
        end
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [7:0] data, input bit accept);
        owsp_wr_en   = 1'b1;
        owsp_wr_addr = addr;
        owsp_wr_data = data;
        tick();
        owsp_wr_en = 1'b0;
        if (accept) begin
            exp_mem[addr] = data;
            if (CRC_ON) exp_busy = 1'b1;
            push($sformatf("wr_ok_a%0d", addr), 1'b0);
        end else begin
            push($sformatf("wr_err_a%0d", addr), 1'b1);
            tick();
            push($sformatf("wr_err_clear_a%0d", addr), 1'b0);
        end
    endtask

    task automatic rd_start(input logic [3:0] addr, input int new_ptr, input bit with_next);
        owsp_rd_start = 1'b1;
        owsp_rd_next  = with_next;
        owsp_rd_addr  = addr;
        tick();
        owsp_rd_start = 1'b0;
        owsp_rd_next  = 1'b0;
        exp_ptr = new_ptr;
        push($sformatf("rd_start_a%0d", addr), 1'b0);
    endtask

    task automatic rd_next(input int new_ptr);
        owsp_rd_next = 1'b1;
        tick();
        owsp_rd_next = 1'b0;
        exp_ptr = new_ptr;
        push($sformatf("rd_next_p%0d", new_ptr), 1'b0);
    endtask

    initial begin
        owpo_rstn     = 1'b0;
        owsp_wr_en    = 1'b0;
        owsp_wr_addr  = '0;
        owsp_wr_data  = '0;
        owsp_rd_start = 1'b0;
        owsp_rd_addr  = '0;
        owsp_rd_next  = 1'b0;
        load_reset_image();
        tick();
        tick();
        push("reset_state", 1'b0);
        owpo_rstn = 1'b1;
        wait_crc();

        do_write(4'd0,  8'hAA, 1'b0);
        do_write(4'd1,  8'h01, 1'b0);
        do_write(4'd8,  8'h5A, 1'b0);
        do_write(4'd12, 8'h33, 1'b0);
        rd_start(4'd0, 0, 1'b0);

        do_write(4'd3, 8'h55, 1'b1);
        wait_crc();
        rd_start(4'd3, 3, 1'b0);

        rd_start(4'd7, 7, 1'b0);
        rd_next(8);
        rd_next(0);
        rd_next(1);
        rd_start(4'd2, 2, 1'b1);
        rd_start(4'd15, 0, 1'b0);

        rd_start(4'd4, 4, 1'b0);
        do_write(4'd4, 8'h3C, 1'b1);
        wait_crc();

        if (CRC_ON) begin
            do_write(4'd2, 8'h11, 1'b1);
            repeat (19) tick();
            push("run_midway", 1'b0);
            do_write(4'd4, 8'h22, 1'b1);
            wait_crc();
        end

        do_write(4'd2, 8'hC3, 1'b1);
        repeat (30) tick();
        owpo_rstn = 1'b0;
        load_reset_image();
        #1;
        push("reset_midway", 1'b0);
        tick();
        owpo_rstn = 1'b1;
        push("reset_release", 1'b0);
        wait_crc();
        rd_start(4'd8, 8, 1'b0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            drain_timeout = 1'b1;
            tick();
        end
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
